// File: rtl/sm_to_tc_serial_if.sv
// Handshake bundle for the serial sign-magnitude to two's-complement converter:
// input channel (magnitude + sign) and output channel (word + overflow flag).
interface sm_to_tc_serial_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mag;
  logic             in_sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  // Converter side
  modport slave (
    input  in_valid, in_mag, in_sign, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_mag, in_sign, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/sm_to_tc_serial.sv
// Bit-serial sign-magnitude to two's-complement, LSB first; out_valid WIDTH+1 clocks after accept.
// Result holds in DONE until out_ready; inputs are ignored (not queued) while busy.
module sm_to_tc_serial #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  sm_to_tc_serial_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q;
  logic             seen_one_q;
  logic             ovf_q;

  logic accept;
  logic cur_bit;
  logic out_bit;
  logic ovf_in;

  assign accept  = bus.in_valid && (state_q == IDLE);
  assign cur_bit = shift_q[0];

  // Negation LSB-first: copy bits up to and including the first 1, invert the rest.
  assign out_bit = (sign_q && seen_one_q) ? ~cur_bit : cur_bit;

  // Negative values fit only up to magnitude 2^(WIDTH-1); positives only below it.
  assign ovf_in = bus.in_sign ? (bus.in_mag[WIDTH-1] & (|bus.in_mag[WIDTH-2:0]))
                              : bus.in_mag[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      seen_one_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q    <= bus.in_mag;
            sign_q     <= bus.in_sign;
            seen_one_q <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= ovf_in;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          result_q   <= {out_bit, result_q[WIDTH-1:1]};
          shift_q    <= {1'b0, shift_q[WIDTH-1:1]};
          seen_one_q <= seen_one_q | cur_bit;
          cnt_q      <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = result_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_sm_to_tc_serial.sv
// Directed corners, backpressure, mid-conversion reset and a randomized stream against a value-level model.
module tb_sm_to_tc_serial;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   lat;

  sm_to_tc_serial_if #(.WIDTH(W)) bus ();

  sm_to_tc_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value-level model: interpret sign/magnitude as an integer, wrap to W bits, flag out-of-range.
  function automatic logic [31:0] model_data(input logic [31:0] mag, input logic sign);
    longint v;
    v = sign ? -longint'(mag) : longint'(mag);
    return v[31:0];
  endfunction

  function automatic logic model_ovf(input logic [31:0] mag, input logic sign);
    longint v;
    v = sign ? -longint'(mag) : longint'(mag);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  // Called at a negedge; returns at the negedge where out_valid is first seen (or budget spent).
  task automatic send(input logic [31:0] mag, input logic sign, input bit busy_poke);
    int waited;
    bus.in_valid = 1'b1;
    bus.in_mag   = mag;
    bus.in_sign  = sign;
    waited = 0;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (busy_poke) begin
      bus.in_valid = 1'b1;
      bus.in_mag   = 32'h0000_1234;
      bus.in_sign  = 1'b0;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_mag   = $urandom;
      bus.in_sign  = 1'($urandom);
    end
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_out(input int stall);
    for (int i = 0; i < stall; i++) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] mag;
    logic        sign;
    logic [31:0] data;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    checks   = 0;
    failures = 0;
    bus.in_valid  = 1'b0;
    bus.in_mag    = '0;
    bus.in_sign   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{32'h0000_0005, 1'b0, 32'h0000_0005, 1'b0};
    vecs[1] = '{32'h0000_0005, 1'b1, 32'hFFFF_FFFB, 1'b0};
    vecs[2] = '{32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};
    vecs[4] = '{32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0};
    vecs[5] = '{32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1};
    vecs[6] = '{32'h8000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1};
    vecs[7] = '{32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data",  bus.out_data,           32'd0);
    check("rst_out_ovf",   {31'd0, bus.out_ovf},   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed sign/overflow corners
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].mag, vecs[i].sign, 1'b0);
      check($sformatf("dir%0d_latency", i), lat, 32'd33);
      check($sformatf("dir%0d_data", i), bus.out_data, vecs[i].data);
      check($sformatf("dir%0d_ovf", i), {31'd0, bus.out_ovf}, {31'd0, vecs[i].ovf});
      finish_out(0);
      check($sformatf("dir%0d_idle_after", i), {31'd0, bus.in_ready}, 32'd1);
      check($sformatf("dir%0d_valid_drop", i), {31'd0, bus.out_valid}, 32'd0);
    end

    // Backpressure with a competing input held valid while busy
    send(32'h0000_0055, 1'b1, 1'b1);
    check("bp_latency", lat, 32'd33);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
      check("bp_out_data",  bus.out_data,           32'hFFFF_FFAB);
      check("bp_out_ovf",   {31'd0, bus.out_ovf},   32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    finish_out(0);
    check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, bus.in_ready},  32'd1);

    // Asynchronous reset while bit 12 is being shifted
    bus.in_valid = 1'b1;
    bus.in_mag   = 32'hDEAD_BEEF;
    bus.in_sign  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_rst_busy", {31'd0, bus.in_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_out_data",  bus.out_data,           32'd0);
    check("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("mid_rst_out_ovf",   {31'd0, bus.out_ovf},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h0000_0003, 1'b1, 1'b0);
    check("post_rst_latency", lat, 32'd33);
    check("post_rst_data", bus.out_data, 32'hFFFF_FFFD);
    check("post_rst_ovf",  {31'd0, bus.out_ovf}, 32'd0);
    finish_out(1);

    // Randomized stream with biased magnitudes and random consumer stalls
    for (int n = 0; n < 500; n++) begin
      logic [31:0] mag;
      logic        sign;
      logic [31:0] exp_data;
      logic        exp_ovf;
      case ($urandom_range(0, 3))
        0:       mag = $urandom;
        1:       mag = 32'($urandom_range(0, 15));
        2:       mag = 32'h8000_0000 + 32'($urandom_range(0, 2)) - 32'd1;
        default: mag = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
      endcase
      sign     = 1'($urandom);
      exp_data = model_data(mag, sign);
      exp_ovf  = model_ovf(mag, sign);
      send(mag, sign, 1'($urandom));
      check($sformatf("rnd%0d_data", n), bus.out_data, exp_data);
      check($sformatf("rnd%0d_ovf", n), {31'd0, bus.out_ovf}, {31'd0, exp_ovf});
      bus.in_valid = 1'b0;
      finish_out(int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sm_to_tc_serial.md
# sm_to_tc_serial

Bit-serial sign-magnitude to two's-complement converter for the smart-home datapath. It is the inverse of the conditional-negate stage that turns signed sensor and actuator values into sign plus magnitude. It accepts a magnitude and sign over a valid/ready handshake and rebuilds the two's-complement word LSB-first, one bit per clock, to keep area small. It sits between the control/arithmetic units, which produce sign-magnitude values, and the register file and output drivers, which consume two's-complement values.

## Interface
- WIDTH, 32, data width in bits; legal values WIDTH >= 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_mag/in_sign are valid
- in_ready  output  1  block can accept an input
- in_mag  input  WIDTH  unsigned magnitude
- in_sign  input  1  1 = negative
- out_valid  output  1  out_data/out_ovf are valid
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  two's-complement result (modulo 2^WIDTH)
- out_ovf  output  1  value is not representable in WIDTH-bit two's complement

## Operation
- One clock domain; reset is asynchronous and active-low.
- FSM states:
  - IDLE: in_ready=1. Transfer when in_valid & in_ready; go to SHIFT.
  - SHIFT: processes exactly WIDTH bits, then goes to DONE.
  - DONE: out_valid=1. Transfer when out_ready=1; go to IDLE.
- On accept, register the following:
  - shift reg ← in_mag
  - sign_r ← in_sign
  - seen_one ← 0
  - bit counter ← 0
  - ovf_r ← in_sign ? (in_mag[WIDTH-1] & |in_mag[WIDTH-2:0]) : in_mag[WIDTH-1]
- Each SHIFT cycle, with b = shift reg LSB:
  - output bit = sign_r & seen_one ? ~b : b
  - seen_one ← seen_one | b
  - output bit shifts into result reg at the MSB; result reg shifts right
  - shift reg shifts right
  - counter increments; leave SHIFT when counter = WIDTH-1
- Result values:
  - Negative zero (sign=1, mag=0) yields 0 with ovf=0.
  - sign=1, mag=2^(WIDTH-1) yields 2^(WIDTH-1), the most negative value, with ovf=0.
  - On overflow, out_data is the modular result and out_ovf=1; the block does not saturate.
- out_data and out_ovf hold stable throughout DONE regardless of inputs.
- in_ready=0 in SHIFT and DONE. Inputs presented then are ignored, not queued.
- No back-to-back bypass: after the output handshake, one IDLE cycle precedes the next accept.
- Reset values, also applied on reset mid-SHIFT or mid-DONE:
  - state=IDLE, in_ready=1
  - out_valid=0, out_data=0, out_ovf=0
  - all internal registers = 0
  - any in-flight conversion is discarded

## Timing
- Accept edge = T. SHIFT occupies edges T+1..T+WIDTH.
- out_valid rises after edge T+WIDTH; latency is WIDTH+1 clocks from accept to out_valid.
- All outputs are registered or decoded from state only. There is no combinational path from in_* or out_ready to any output.
- out_valid stays high until the edge where out_ready=1; the FSM enters IDLE on that edge.
- Minimum throughput: one conversion per WIDTH+3 clocks.

## Test plan
- Positive value, in-range: WIDTH=32, mag=0x00000005, sign=0 → out_data=0x00000005, ovf=0, out_valid exactly 33 clocks after accept.
- Negative value: mag=5, sign=1 → out_data=0xFFFFFFFB, ovf=0. Check corners:
  - mag=1, sign=1 → 0xFFFFFFFF
  - mag=0, sign=1 → 0x00000000, ovf=0
- Overflow boundaries:
  - mag=0x80000000, sign=1 → 0x80000000, ovf=0
  - mag=0x80000000, sign=0 → 0x80000000, ovf=1
  - mag=0x80000001, sign=1 → 0x7FFFFFFF, ovf=1
  - mag=0x7FFFFFFF, sign=0 → 0x7FFFFFFF, ovf=0
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_data/out_ovf stable, in_ready=0. While busy, drive in_valid with mag=0x1234 → ignored. Release out_ready → IDLE next cycle.
- Reset mid-operation: assert rst_n=0 asynchronously at SHIFT bit 12 → outputs go immediately to out_valid=0, out_data=0, in_ready=1. The next conversion, mag=3, sign=1, yields 0xFFFFFFFD.
- Randomized stream: 500 random mag/sign with random out_ready stalls → each result matches the reference model (sign ? -mag : mag) mod 2^32, with correct ovf, in order.
